fp_mul_scheduler: RTL

FP_MUL_SCHEDULER -- requirements
Module: fp_mul_scheduler

---
 rtl/fp_mul_scheduler_pkg.sv | 21 ++
 rtl/fp32_mul.sv | 29 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/fp_mul_scheduler.sv | 101 ++++++++++
 4 files changed

// File: rtl/fp_mul_scheduler_pkg.sv
// Shared types and FP32 field constants for the multiplier scheduler.
// The state encoding lives here so the top and any future observers agree on it.
package fp_mul_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_MAN_MSB  = 22;
  localparam int FP_BIAS     = 127;

  function automatic logic fp_exp_is_zero(input logic [31:0] x);
    return x[FP_EXP_MSB:FP_EXP_LSB] == '0;
  endfunction

endpackage

// File: rtl/fp32_mul.sv
// Combinational FP32 multiplier: normal operands only, product mantissa truncated.
// Zero, NaN and Inf handling is left to the caller.
module fp32_mul
  import fp_mul_scheduler_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result
);

  logic [23:0] man_a, man_b;
  logic [47:0] prod;
  logic [9:0]  exp_sum;
  logic [22:0] man_n;
  logic        unused_bits;

  assign man_a = {1'b1, A[FP_MAN_MSB:0]};
  assign man_b = {1'b1, B[FP_MAN_MSB:0]};
  assign prod  = 48'(man_a) * 48'(man_b);

  // A product in [2,4) sets bit 47; shift one place and bump the exponent.
  assign exp_sum = 10'(A[FP_EXP_MSB:FP_EXP_LSB]) + 10'(B[FP_EXP_MSB:FP_EXP_LSB])
                 - 10'(FP_BIAS) + 10'(prod[47]);
  assign man_n   = prod[47] ? prod[46:24] : prod[45:23];

  assign result      = {A[FP_SIGN_BIT] ^ B[FP_SIGN_BIT], exp_sum[7:0], man_n};
  assign unused_bits = ^{prod[22:0], exp_sum[9:8]};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches ptr, ptr+1, ... (mod NREQ) and grants the first
// active request, returning both a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int            j;
      logic [IDW-1:0] jj;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IDW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Shares one FP32 multiplier among NREQ requesters: round-robin accept,
// one cycle of execution, then hold the response until the consumer takes it.
module fp_mul_scheduler
  import fp_mul_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_result,
  output logic              busy
);

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  rsp_id_q;
  logic [31:0]     rsp_result_q;
  logic [31:0]     op_a_q, op_b_q;
  logic [31:0]     mul_res, result_d;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [NREQ-1:0] ready_c;
  logic            accept;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  fp32_mul u_mul (
    .A      (op_a_q),
    .B      (op_b_q),
    .result (mul_res)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_c = '0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          ready_c = gnt;
          accept  = 1'b1;
          ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A zero exponent on either side forces a signed zero regardless of the multiplier.
  assign result_d = (fp_exp_is_zero(op_a_q) || fp_exp_is_zero(op_b_q))
                  ? {op_a_q[FP_SIGN_BIT] ^ op_b_q[FP_SIGN_BIT], 31'b0}
                  : mul_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) rsp_id_q <= gnt_idx;
      if (state_q == ST_EXEC) rsp_result_q <= result_d;
    end
  end

  // Operand capture needs no reset: it is only consumed after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_q <= req_a[int'(gnt_idx)*32 +: 32];
      op_b_q <= req_b[int'(gnt_idx)*32 +: 32];
    end
  end

  assign req_ready  = rst_n ? ready_c : '0;
  assign rsp_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule
